// File: rtl/hilo_commit_buffer_pkg.sv
// rtl/hilo_commit_buffer_pkg.sv - shared HI/LO indices, widths, FIFO depth and entry type
package hilo_commit_buffer_pkg;

    localparam int HI_IDX     = 1;
    localparam int LO_IDX     = 0;
    localparam int HALF_W     = 32;
    localparam int HILO_W     = 2 * HALF_W;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [1:0]        we;
        logic [HILO_W-1:0] data;
    } hilo_entry_t;

    function automatic logic [HALF_W-1:0] half_of(input logic [HILO_W-1:0] word, input int idx);
        return word[idx*HALF_W +: HALF_W];
    endfunction

endpackage

// File: rtl/hilo_pending_fifo.sv
// rtl/hilo_pending_fifo.sv - 2-entry pending HI/LO FIFO with per-half youngest lookup (HILO_FORWARD_EN)
module hilo_pending_fifo
    import hilo_commit_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  hilo_entry_t       push_entry,
    input  logic [HILO_W-1:0] arch,
    output hilo_entry_t       head,
    output logic [CNT_W-1:0]  count,
    output logic [HILO_W-1:0] view
);

    hilo_entry_t      entries [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = entries[rd_ptr];

    // flush wins over push/pop; the top has already used head for a same-cycle retire
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef HILO_FORWARD_EN
    hilo_entry_t young;
    assign young = entries[wr_ptr - PTR_W'(1)];

    always_comb begin
        view = arch;
        for (int h = 0; h < 2; h++) begin
            if ((count != '0) && young.we[h]) begin
                view[h*HALF_W +: HALF_W] = half_of(young.data, h);
            end else if ((count == CNT_W'(FIFO_DEPTH)) && head.we[h]) begin
                view[h*HALF_W +: HALF_W] = half_of(head.data, h);
            end
        end
    end
`else
    assign view = arch;
`endif

endmodule

// File: rtl/hilo_commit_buffer.sv
// rtl/hilo_commit_buffer.sv - HI/LO commit buffer top; HILO_FORWARD_EN selects forwarding vs stall
module hilo_commit_buffer
    import hilo_commit_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mdu_issue,
    input  logic              mdu_data_ok,
    input  logic [1:0]        mdu_we,
    input  logic [HILO_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    input  logic              commit,
    input  logic              cancel,
    output logic [HILO_W-1:0] hilo_rdata,
    output logic              hilo_busy,
    output logic [HILO_W-1:0] arch_hilo
);

    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
    logic [1:0]        outstanding;
    logic [CNT_W-1:0]  count;
    hilo_entry_t       head;
    hilo_entry_t       push_entry;
    logic              accept;
    logic              push;
    logic              retire;

    assign mdu_ready  = (count < CNT_W'(FIFO_DEPTH)) || commit;
    // a result arriving while full without a commit is dropped and leaves all state alone
    assign accept     = mdu_data_ok && mdu_ready && !cancel;
    assign push       = accept && (mdu_we != 2'b00);
    assign retire     = commit && (count != '0);
    assign push_entry = {mdu_we, mdu_wdata};
    assign arch_hilo  = {hi, lo};

    hilo_pending_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (retire),
        .flush      (cancel),
        .push_entry (push_entry),
        .arch       (arch_hilo),
        .head       (head),
        .count      (count),
        .view       (hilo_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (retire) begin
            if (head.we[HI_IDX]) hi <= half_of(head.data, HI_IDX);
            if (head.we[LO_IDX]) lo <= half_of(head.data, LO_IDX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            outstanding <= '0;
        end else if (mdu_issue && !accept && (outstanding != 2'd3)) begin
            outstanding <= outstanding + 2'd1;
        end else if (!mdu_issue && accept && (outstanding != 2'd0)) begin
            outstanding <= outstanding - 2'd1;
        end
    end

`ifdef HILO_FORWARD_EN
    assign hilo_busy = (outstanding != 2'd0) || mdu_issue;
`else
    // without forwarding, readers must also wait for pending entries to retire
    assign hilo_busy = (outstanding != 2'd0) || mdu_issue || (count != '0);
`endif

endmodule

// File: tb/tb_hilo_commit_buffer.sv
// tb/tb_hilo_commit_buffer.sv - randomized and directed bench against a queue-based HI/LO model
module tb_hilo_commit_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdu_issue;
    logic        mdu_data_ok;
    logic [1:0]  mdu_we;
    logic [63:0] mdu_wdata;
    logic        mdu_ready;
    logic        commit;
    logic        cancel;
    logic [63:0] hilo_rdata;
    logic        hilo_busy;
    logic [63:0] arch_hilo;

    always #5 clk = ~clk;

    hilo_commit_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .mdu_issue   (mdu_issue),
        .mdu_data_ok (mdu_data_ok),
        .mdu_we      (mdu_we),
        .mdu_wdata   (mdu_wdata),
        .mdu_ready   (mdu_ready),
        .commit      (commit),
        .cancel      (cancel),
        .hilo_rdata  (hilo_rdata),
        .hilo_busy   (hilo_busy),
        .arch_hilo   (arch_hilo)
    );

    typedef struct {
        logic [1:0]  we;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_out;
    int          checks;
    int          errors;

    logic [63:0] s_rdata;
    logic [63:0] s_arch;
    logic        s_ready;
    logic        s_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_view();
        logic [63:0] v;
        v = {m_hi, m_lo};
`ifdef HILO_FORWARD_EN
        foreach (q[i]) begin
            if (q[i].we[1]) v[63:32] = q[i].data[63:32];
            if (q[i].we[0]) v[31:0]  = q[i].data[31:0];
        end
`endif
        return v;
    endfunction

    task automatic model_step(input logic i_issue, input logic i_ok, input logic [1:0] i_we,
                              input logic [63:0] i_wd, input logic i_commit, input logic i_cancel,
                              input logic i_rst);
        ent_t e;
        bit   ready;
        bit   acc;
        if (i_rst) begin
            q.delete();
            m_hi  = '0;
            m_lo  = '0;
            m_out = 0;
            return;
        end
        ready = (q.size() < 2) || i_commit;
        acc   = i_ok && ready && !i_cancel;
        if (i_commit && q.size() > 0) begin
            e = q.pop_front();
            if (e.we[1]) m_hi = e.data[63:32];
            if (e.we[0]) m_lo = e.data[31:0];
        end
        if (i_cancel) begin
            q.delete();
            m_out = 0;
        end else begin
            if (acc && i_we != 2'b00) begin
                e.we   = i_we;
                e.data = i_wd;
                q.push_back(e);
            end
            m_out = m_out + int'(i_issue) - int'(acc);
            if (m_out > 3) m_out = 3;
            if (m_out < 0) m_out = 0;
        end
    endtask

    task automatic drive_cycle(input logic i_issue, input logic i_ok, input logic [1:0] i_we,
                               input logic [63:0] i_wd, input logic i_commit, input logic i_cancel,
                               input logic i_rst);
        logic exp_busy;
        @(negedge clk);
        rst         = i_rst;
        mdu_issue   = i_issue;
        mdu_data_ok = i_ok;
        mdu_we      = i_we;
        mdu_wdata   = i_wd;
        commit      = i_commit;
        cancel      = i_cancel;
        #1;
        exp_busy = (m_out != 0) || i_issue;
`ifndef HILO_FORWARD_EN
        exp_busy = exp_busy || (q.size() != 0);
`endif
        check_eq("mdu_ready", 64'(mdu_ready), 64'((q.size() < 2) || i_commit));
        check_eq("hilo_busy", 64'(hilo_busy), 64'(exp_busy));
        check_eq("hilo_rdata", hilo_rdata, model_view());
        check_eq("arch_hilo", arch_hilo, {m_hi, m_lo});
        s_rdata = hilo_rdata;
        s_arch  = arch_hilo;
        s_ready = mdu_ready;
        s_busy  = hilo_busy;
        @(posedge clk);
        model_step(i_issue, i_ok, i_we, i_wd, i_commit, i_cancel, i_rst);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [1:0] we, input logic [63:0] wd, input logic c);
        drive_cycle(1'b0, 1'b1, we, wd, c, 1'b0, 1'b0);
    endtask

    initial begin
        logic        r_rst, r_issue, r_ok, r_commit, r_cancel;
        logic [1:0]  r_we;
        logic [63:0] r_wd;
        checks = 0;
        errors = 0;
        m_hi = '0;
        m_lo = '0;
        m_out = 0;
        rst = 1'b1;
        mdu_issue = 1'b0;
        mdu_data_ok = 1'b0;
        mdu_we = 2'b00;
        mdu_wdata = '0;
        commit = 1'b0;
        cancel = 1'b0;
        repeat (2) @(posedge clk);
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b1);

        idle();
        check_eq("reset_ready", 64'(s_ready), 64'd1);
        check_eq("reset_busy", 64'(s_busy), 64'd0);
        check_eq("reset_rdata", s_rdata, 64'h0);
        check_eq("reset_arch", s_arch, 64'h0);

        // single op: issue, result three cycles later, then commit
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        push(2'b11, 64'h00000005_00000007, 1'b0);
        idle();
`ifdef HILO_FORWARD_EN
        check_eq("single_busy", 64'(s_busy), 64'd0);
        check_eq("single_rdata", s_rdata, 64'h00000005_00000007);
`else
        check_eq("single_busy_nofwd", 64'(s_busy), 64'd1);
        check_eq("single_rdata_nofwd", s_rdata, 64'h0);
`endif
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0);
        idle();
        check_eq("single_arch", s_arch, 64'h00000005_00000007);
        check_eq("single_busy_after", 64'(s_busy), 64'd0);

        // partial write of LO only
        push(2'b11, 64'h11111111_22222222, 1'b0);
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0);
        push(2'b01, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        idle();
`ifdef HILO_FORWARD_EN
        check_eq("partial_rdata", s_rdata, 64'h11111111_BBBBBBBB);
`else
        check_eq("partial_rdata_nofwd", s_rdata, 64'h11111111_22222222);
        check_eq("partial_busy_nofwd", 64'(s_busy), 64'd1);
`endif
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0);
        idle();
        check_eq("partial_arch", s_arch, 64'h11111111_BBBBBBBB);

        // fill, forward youngest, push-with-commit while full, then overflow drop
        push(2'b11, 64'hA0A0A0A0_A1A1A1A1, 1'b0);
        push(2'b11, 64'hB0B0B0B0_B1B1B1B1, 1'b0);
        idle();
        check_eq("full_ready", 64'(s_ready), 64'd0);
`ifdef HILO_FORWARD_EN
        check_eq("full_rdata", s_rdata, 64'hB0B0B0B0_B1B1B1B1);
`endif
        push(2'b11, 64'hC0C0C0C0_C1C1C1C1, 1'b1);
        idle();
        check_eq("full_commit_arch", s_arch, 64'hA0A0A0A0_A1A1A1A1);
        check_eq("full_commit_ready", 64'(s_ready), 64'd0);
`ifdef HILO_FORWARD_EN
        check_eq("full_commit_rdata", s_rdata, 64'hC0C0C0C0_C1C1C1C1);
`endif
        push(2'b11, 64'hD0D0D0D0_D1D1D1D1, 1'b0);
        idle();
        check_eq("drop_ready", 64'(s_ready), 64'd0);
`ifdef HILO_FORWARD_EN
        check_eq("drop_rdata", s_rdata, 64'hC0C0C0C0_C1C1C1C1);
`endif

        // cancel with commit retires oldest and clears everything else
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 2'b11, 64'hE0E0E0E0_E1E1E1E1, 1'b1, 1'b1, 1'b0);
        idle();
        check_eq("cancel_arch", s_arch, 64'hB0B0B0B0_B1B1B1B1);
        check_eq("cancel_ready", 64'(s_ready), 64'd1);
        check_eq("cancel_busy", 64'(s_busy), 64'd0);
        check_eq("cancel_rdata", s_rdata, 64'hB0B0B0B0_B1B1B1B1);

        // mid-operation reset with outstanding=2, count=1
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
        push(2'b10, 64'hF0F0F0F0_F1F1F1F1, 1'b0);
        drive_cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b1);
        idle();
        check_eq("rst_ready", 64'(s_ready), 64'd1);
        check_eq("rst_busy", 64'(s_busy), 64'd0);
        check_eq("rst_rdata", s_rdata, 64'h0);
        check_eq("rst_arch", s_arch, 64'h0);

        for (int n = 0; n < 3000; n++) begin
            r_rst    = ($urandom_range(0, 99) == 0);
            r_issue  = ($urandom_range(0, 9) < 4);
            r_ok     = ($urandom_range(0, 9) < 4);
            r_we     = 2'($urandom_range(0, 3));
            r_wd     = {$urandom, $urandom};
            r_commit = ($urandom_range(0, 9) < 3);
            r_cancel = ($urandom_range(0, 19) == 0);
            if (q.size() == 2 && !r_commit) r_ok = 1'b0;
            drive_cycle(r_issue, r_ok, r_we, r_wd, r_commit, r_cancel, r_rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
